// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Shares a single async_fifo write port among NUM_REQ
//               requesters in the w_clk domain. Round-robin arbitration with
//               bounded bursts: the owner keeps the port for up to BURST_MAX
//               accepted words, then the port is released and re-arbitrated.
//               FIFO full backpressure stalls the owner without losing words.
//
// Ports       : w_clk     - write-domain clock
//               w_rst_n   - asynchronous active-low reset
//               req       - per-requester valid, held with data until ack
//               req_data  - flattened data, requester i at [i*WIDTH +: WIDTH]
//               ack       - one-hot accept, word consumed on the ack edge
//               full      - FIFO full flag (w_clk domain)
//               w_en      - FIFO write enable
//               w_data    - FIFO write data
//               busy      - high while a burst is in progress
//               owner     - current or last owner index
//
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                       w_clk,
  input  logic                       w_rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         ack,
  input  logic                       full,
  output logic                       w_en,
  output logic [WIDTH-1:0]           w_data,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_MAX + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);
  // Pointer starts at the top index so that requester 0 wins first.
  localparam logic [OW-1:0] PTR_INIT = OW'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t        state_q,     state_d;
  logic [OW-1:0] owner_q,     owner_d;
  logic [OW-1:0] last_ptr_q,  last_ptr_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;

  logic [OW-1:0] winner;
  logic          winner_vld;
  logic          grant;
  logic          accept;

  // --------------------------------------------------------------------------
  // Round-robin winner: first set req bit searching upward from last_ptr+1,
  // wrapping modulo NUM_REQ. The last candidate examined is last_ptr itself,
  // so a lone requester re-wins after its own release.
  // --------------------------------------------------------------------------
  always_comb begin
    logic [OW-1:0] idx;
    winner     = last_ptr_q;
    winner_vld = 1'b0;
    idx        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = OW'((int'(last_ptr_q) + k) % NUM_REQ);
      if (!winner_vld && req[idx]) begin
        winner     = idx;
        winner_vld = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write-port outputs: combinational from registered state, req and full so
  // that a full assertion blocks the write in the same cycle.
  // --------------------------------------------------------------------------
  assign grant  = (state_q == ST_BURST) && req[owner_q];
  assign accept = grant && !full;

  always_comb begin
    ack = '0;
    if (accept) begin
      ack[owner_q] = 1'b1;
    end
  end

  assign w_en   = accept;
  assign w_data = accept ? req_data[int'(owner_q)*WIDTH +: WIDTH] : '0;
  assign busy   = (state_q == ST_BURST);
  assign owner  = owner_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_ptr_d  = last_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (winner_vld) begin
          owner_d     = winner;
          burst_cnt_d = '0;
          state_d     = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!req[owner_q]) begin
          // Owner withdrew: give the port up without accepting anything.
          state_d    = ST_IDLE;
          last_ptr_d = owner_q;
        end else if (!full) begin
          if (burst_cnt_q == CNT_LAST) begin
            state_d    = ST_IDLE;
            last_ptr_d = owner_q;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
        // full with a valid owner: everything holds, stall of any length.
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      last_ptr_q  <= PTR_INIT;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_ptr_q  <= last_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule
`default_nettype wire
